// File: rtl/rptr_handler.sv
// Read-side pointer handler for an asynchronous FIFO: read pointer generation,
// write-pointer synchronization, and registered empty/almost-empty/occupancy flags.
module rptr_handler #(
   parameter int PTR_WIDTH   = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AE_LEVEL    = 1
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic                 r_en,
   input  logic [PTR_WIDTH:0]   g_wptr,
   output logic [PTR_WIDTH:0]   b_rptr,
   output logic [PTR_WIDTH:0]   g_rptr,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [PTR_WIDTH:0]   rd_count,
   output logic                 r_valid,
   output logic                 underflow
);

   localparam logic [PTR_WIDTH:0] AE_THRESH = (PTR_WIDTH+1)'(AE_LEVEL);

   logic [PTR_WIDTH:0] sync_reg [SYNC_STAGES];
   logic [PTR_WIDTH:0] g_wptr_sync;
   logic [PTR_WIDTH:0] b_wptr_sync;
   logic [PTR_WIDTH:0] b_rptr_next;
   logic [PTR_WIDTH:0] g_rptr_next;
   logic [PTR_WIDTH:0] count_next;
   logic               accept;

   // Plain flop chain; nothing may sit between stages or metastability filtering suffers.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
      end else begin
         sync_reg[0] <= g_wptr;
         for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      end
   end

   assign g_wptr_sync = sync_reg[SYNC_STAGES-1];

   // Each binary bit is the XOR of all gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi <= PTR_WIDTH; gi++) begin : g_g2b
         assign b_wptr_sync[gi] = ^g_wptr_sync[PTR_WIDTH:gi];
      end
   endgenerate

   always_comb begin
      accept      = r_en & ~empty;
      b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, accept};
      g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1);
      count_next  = b_wptr_sync - b_rptr_next;
   end

   // Flags use the post-read pointer so a read takes effect on the same edge.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         b_rptr       <= '0;
         g_rptr       <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_count     <= '0;
         r_valid      <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         b_rptr       <= b_rptr_next;
         g_rptr       <= g_rptr_next;
         empty        <= (g_rptr_next == g_wptr_sync);
         almost_empty <= (count_next <= AE_THRESH);
         rd_count     <= count_next;
         r_valid      <= accept;
         underflow    <= r_en & empty;
      end
   end

endmodule
